// File: rtl/md5_compress_pkg.sv
// Shared constants and small combinational helpers for the MD5 compression engine.
// Holds shift amounts, IV words, state encodings and the per-round F / g / rotate functions.
package md5_compress_pkg;

  localparam logic [4:0] S11 = 5'd7,  S12 = 5'd12, S13 = 5'd17, S14 = 5'd22;
  localparam logic [4:0] S21 = 5'd5,  S22 = 5'd9,  S23 = 5'd14, S24 = 5'd20;
  localparam logic [4:0] S31 = 5'd4,  S32 = 5'd11, S33 = 5'd16, S34 = 5'd23;
  localparam logic [4:0] S41 = 5'd6,  S42 = 5'd10, S43 = 5'd15, S44 = 5'd21;

  localparam logic [31:0] MD5_IV_A = 32'h67452301;
  localparam logic [31:0] MD5_IV_B = 32'hefcdab89;
  localparam logic [31:0] MD5_IV_C = 32'h98badcfe;
  localparam logic [31:0] MD5_IV_D = 32'h10325476;

  localparam logic [1:0] MD5_ST_IDLE  = 2'd0;
  localparam logic [1:0] MD5_ST_RUN   = 2'd1;
  localparam logic [1:0] MD5_ST_FINAL = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE  = MD5_ST_IDLE,
    ST_RUN   = MD5_ST_RUN,
    ST_FINAL = MD5_ST_FINAL
  } md5_state_e;

  // grp is round[5:4]: one boolean function per 16-round group
  function automatic logic [31:0] md5_f(input logic [1:0] grp, input logic [31:0] b,
                                        input logic [31:0] c, input logic [31:0] d);
    case (grp)
      2'd0:    return (b & c) | (~b & d);
      2'd1:    return (b & d) | (c & ~d);
      2'd2:    return b ^ c ^ d;
      default: return c ^ (b | ~d);
    endcase
  endfunction

  // All multipliers only need round mod 16, so 4-bit arithmetic gives the mod-16 result directly
  function automatic logic [3:0] md5_g(input logic [5:0] rnd);
    case (rnd[5:4])
      2'd0:    return rnd[3:0];
      2'd1:    return rnd[3:0] * 4'd5 + 4'd1;
      2'd2:    return rnd[3:0] * 4'd3 + 4'd5;
      default: return rnd[3:0] * 4'd7;
    endcase
  endfunction

  function automatic logic [31:0] rotl32(input logic [31:0] x, input logic [4:0] s);
    return (x << s) | (x >> (6'd32 - {1'b0, s}));
  endfunction

endpackage

// File: rtl/md5_compress_lut.sv
// Round-indexed lookup tables: klut gives the additive constant K[i], slut the rotate amount s[i].
// Both are purely combinational, 6-bit round in.
module klut (
  input  logic [5:0]  i_round,
  output logic [31:0] o_k
);
  localparam logic [31:0] K_TAB [64] = '{
    32'hd76aa478, 32'he8c7b756, 32'h242070db, 32'hc1bdceee,
    32'hf57c0faf, 32'h4787c62a, 32'ha8304613, 32'hfd469501,
    32'h698098d8, 32'h8b44f7af, 32'hffff5bb1, 32'h895cd7be,
    32'h6b901122, 32'hfd987193, 32'ha679438e, 32'h49b40821,
    32'hf61e2562, 32'hc040b340, 32'h265e5a51, 32'he9b6c7aa,
    32'hd62f105d, 32'h02441453, 32'hd8a1e681, 32'he7d3fbc8,
    32'h21e1cde6, 32'hc33707d6, 32'hf4d50d87, 32'h455a14ed,
    32'ha9e3e905, 32'hfcefa3f8, 32'h676f02d9, 32'h8d2a4c8a,
    32'hfffa3942, 32'h8771f681, 32'h6d9d6122, 32'hfde5380c,
    32'ha4beea44, 32'h4bdecfa9, 32'hf6bb4b60, 32'hbebfbc70,
    32'h289b7ec6, 32'heaa127fa, 32'hd4ef3085, 32'h04881d05,
    32'hd9d4d039, 32'he6db99e5, 32'h1fa27cf8, 32'hc4ac5665,
    32'hf4292244, 32'h432aff97, 32'hab9423a7, 32'hfc93a039,
    32'h655b59c3, 32'h8f0ccc92, 32'hffeff47d, 32'h85845dd1,
    32'h6fa87e4f, 32'hfe2ce6e0, 32'ha3014314, 32'h4e0811a1,
    32'hf7537e82, 32'hbd3af235, 32'h2ad7d2bb, 32'heb86d391
  };

  assign o_k = K_TAB[i_round];
endmodule

module slut (
  input  logic [5:0] i_round,
  output logic [4:0] o_s
);
  import md5_compress_pkg::*;

  // Shift depends only on the group (bits 5:4) and position within a 4-round cycle (bits 1:0)
  always_comb begin
    o_s = S11;
    casez (i_round)
      6'b00??00: o_s = S11;
      6'b00??01: o_s = S12;
      6'b00??10: o_s = S13;
      6'b00??11: o_s = S14;
      6'b01??00: o_s = S21;
      6'b01??01: o_s = S22;
      6'b01??10: o_s = S23;
      6'b01??11: o_s = S24;
      6'b10??00: o_s = S31;
      6'b10??01: o_s = S32;
      6'b10??10: o_s = S33;
      6'b10??11: o_s = S34;
      6'b11??00: o_s = S41;
      6'b11??01: o_s = S42;
      6'b11??10: o_s = S43;
      default:   o_s = S44;
    endcase
  end
endmodule

// File: rtl/md5_compress.sv
// Iterative MD5 compression: one round per clock, 65-cycle latency from start to done.
// The chaining value is saved at start and added back in the FINAL cycle.
module md5_compress (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         start_i,
  input  logic         init_i,
  input  logic [0:127] h_i,
  input  logic [0:511] m_i,
  output logic         ready_o,
  output logic         done_o,
  output logic [0:127] h_o
);
  import md5_compress_pkg::*;

  md5_state_e   r_state;
  logic [5:0]   r_round;
  logic [31:0]  r_a, r_b, r_c, r_d;
  logic [31:0]  r_h0, r_h1, r_h2, r_h3;
  logic [31:0]  r_m [16];
  logic [0:127] r_h_out;
  logic         r_done;

  logic [31:0]  w_k, w_f, w_t, w_rot;
  logic [4:0]   w_s;
  logic [3:0]   w_g;
  logic [0:127] w_cv;

  klut u_klut (.i_round(r_round), .o_k(w_k));
  slut u_slut (.i_round(r_round), .o_s(w_s));

  assign w_cv  = init_i ? {MD5_IV_A, MD5_IV_B, MD5_IV_C, MD5_IV_D} : h_i;
  assign w_f   = md5_f(r_round[5:4], r_b, r_c, r_d);
  assign w_g   = md5_g(r_round);
  assign w_t   = r_a + w_f + w_k + r_m[w_g];
  assign w_rot = rotl32(w_t, w_s);

  assign ready_o = (r_state == ST_IDLE);
  assign done_o  = r_done;
  assign h_o     = r_h_out;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= ST_IDLE;
      r_round <= '0;
      r_a     <= '0;
      r_b     <= '0;
      r_c     <= '0;
      r_d     <= '0;
      r_h0    <= '0;
      r_h1    <= '0;
      r_h2    <= '0;
      r_h3    <= '0;
      r_h_out <= '0;
      r_done  <= 1'b0;
      for (int j = 0; j < 16; j++) r_m[j] <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (start_i) begin
            for (int j = 0; j < 16; j++) r_m[j] <= m_i[32*j +: 32];
            r_a     <= w_cv[0:31];
            r_b     <= w_cv[32:63];
            r_c     <= w_cv[64:95];
            r_d     <= w_cv[96:127];
            r_h0    <= w_cv[0:31];
            r_h1    <= w_cv[32:63];
            r_h2    <= w_cv[64:95];
            r_h3    <= w_cv[96:127];
            r_round <= '0;
            r_state <= ST_RUN;
          end
        end
        ST_RUN: begin
          r_a     <= r_d;
          r_d     <= r_c;
          r_c     <= r_b;
          r_b     <= r_b + w_rot;
          r_round <= r_round + 6'd1;
          if (r_round == 6'd63) r_state <= ST_FINAL;
        end
        ST_FINAL: begin
          r_h_out <= {r_h0 + r_a, r_h1 + r_b, r_h2 + r_c, r_h3 + r_d};
          r_done  <= 1'b1;
          r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_md5_compress.sv
// Directed bench for md5_compress: known digests, chaining, busy starts and reset behaviour.
// A behavioural MD5 block function (K derived from sin) supplies the chained expected value.
module tb_md5_compress;

  logic         clk_i = 1'b0;
  logic         rst_i, start_i, init_i;
  logic [0:127] h_i, h_o;
  logic [0:511] m_i;
  logic         ready_o, done_o;

  int checks   = 0;
  int failures = 0;

  localparam logic [0:127] IV        = 128'h67452301efcdab8998badcfe10325476;
  localparam logic [0:511] M_EMPTY   = {32'h00000080, 480'h0};
  localparam logic [0:511] M_ABC     = {32'h80636261, 416'h0, 32'h00000018, 32'h0};
  localparam logic [0:127] EXP_EMPTY = 128'hd98c1dd404b2008f980980e97e42f8ec;
  localparam logic [0:127] EXP_ABC   = 128'h98500190b04fd23c7d3f96d6727fe128;
  localparam int SH [16] = '{7, 12, 17, 22, 5, 9, 14, 20, 4, 11, 16, 23, 6, 10, 15, 21};

  md5_compress dut (
    .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .init_i(init_i),
    .h_i(h_i), .m_i(m_i), .ready_o(ready_o), .done_o(done_o), .h_o(h_o)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, expected finish before 200000");
    $fatal(1);
  end

  function automatic logic [0:127] md5_model(input logic [0:127] h, input logic [0:511] m);
    logic [31:0] a, b, c, d, f, k, x, tmp;
    int g, s;
    real r;
    a = h[0:31]; b = h[32:63]; c = h[64:95]; d = h[96:127];
    for (int i = 0; i < 64; i++) begin
      if (i < 16)      begin f = (b & c) | (~b & d); g = i;              end
      else if (i < 32) begin f = (b & d) | (c & ~d); g = (5 * i + 1) % 16; end
      else if (i < 48) begin f = b ^ c ^ d;          g = (3 * i + 5) % 16; end
      else             begin f = c ^ (b | ~d);       g = (7 * i) % 16;     end
      r = $sin(real'(i + 1));
      if (r < 0.0) r = -r;
      k = 32'(longint'($floor(r * 4294967296.0)));
      x = a + f + k + m[32*g +: 32];
      s = SH[(i / 16) * 4 + i % 4];
      tmp = d; d = c; c = b;
      b = b + ((x << s) | (x >> (32 - s)));
      a = tmp;
    end
    return {h[0:31] + a, h[32:63] + b, h[64:95] + c, h[96:127] + d};
  endfunction

  function automatic logic [0:511] rnd512();
    logic [0:511] v;
    for (int j = 0; j < 16; j++) v[32*j +: 32] = $urandom();
    return v;
  endfunction

  function automatic logic [0:127] rnd128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  // Called at a negedge; returns at the negedge right after the accepting edge (cycle 0).
  task automatic do_start(input logic [0:127] h, input logic [0:511] m, input logic init);
    start_i = 1'b1; h_i = h; m_i = m; init_i = init;
    @(negedge clk_i);
    start_i = 1'b0; h_i = rnd128(); m_i = rnd512(); init_i = 1'($urandom());
  endtask

  task automatic wait_done(input int budget, input bit stop, output int lat, output int nd);
    lat = -1; nd = 0;
    for (int c = 0; c <= budget; c++) begin
      if (done_o === 1'b1) begin
        nd++;
        if (lat < 0) lat = c;
        if (stop) return;
      end
      @(negedge clk_i);
    end
  endtask

  task automatic test_reset();
    rst_i = 1'b1; start_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      init_i = 1'($urandom()); h_i = rnd128(); m_i = rnd512();
      @(negedge clk_i);
      checks++;
      if (ready_o !== 1'b1) begin failures++; $display("FAIL reset_ready cyc=%0d got=%b exp=1", i, ready_o); end
      checks++;
      if (done_o !== 1'b0) begin failures++; $display("FAIL reset_done cyc=%0d got=%b exp=0", i, done_o); end
      checks++;
      if (h_o !== 128'h0) begin failures++; $display("FAIL reset_h_o cyc=%0d got=%h exp=0", i, h_o); end
    end
    rst_i = 1'b0; start_i = 1'b0;
    @(negedge clk_i);
  endtask

  task automatic test_empty();
    int lat, nd;
    do_start(128'h0, M_EMPTY, 1'b1);
    checks++;
    if (ready_o !== 1'b0) begin failures++; $display("FAIL empty_busy got=%b exp=0", ready_o); end
    wait_done(100, 1'b0, lat, nd);
    checks++;
    if (lat !== 65) begin failures++; $display("FAIL empty_latency got=%0d exp=65", lat); end
    checks++;
    if (nd !== 1) begin failures++; $display("FAIL empty_done_count got=%0d exp=1", nd); end
    checks++;
    if (h_o !== EXP_EMPTY) begin failures++; $display("FAIL empty_digest got=%h exp=%h", h_o, EXP_EMPTY); end
    checks++;
    if (h_o !== md5_model(IV, M_EMPTY)) begin failures++; $display("FAIL empty_model got=%h exp=%h", h_o, md5_model(IV, M_EMPTY)); end
  endtask

  task automatic test_abc();
    int lat, nd;
    do_start(rnd128(), M_ABC, 1'b1);
    wait_done(100, 1'b0, lat, nd);
    checks++;
    if (lat !== 65) begin failures++; $display("FAIL abc_latency got=%0d exp=65", lat); end
    checks++;
    if (nd !== 1) begin failures++; $display("FAIL abc_done_count got=%0d exp=1", nd); end
    checks++;
    if (h_o !== EXP_ABC) begin failures++; $display("FAIL abc_digest got=%h exp=%h", h_o, EXP_ABC); end
    checks++;
    if (ready_o !== 1'b1) begin failures++; $display("FAIL abc_idle_ready got=%b exp=1", ready_o); end
  endtask

  task automatic test_back_to_back();
    int lat, nd;
    logic [0:127] exp_chain;
    exp_chain = md5_model(EXP_ABC, M_ABC);
    do_start(rnd128(), M_ABC, 1'b1);
    wait_done(100, 1'b1, lat, nd);
    checks++;
    if (h_o !== EXP_ABC) begin failures++; $display("FAIL b2b_first_digest got=%h exp=%h", h_o, EXP_ABC); end
    // start issued in the done cycle itself
    do_start(EXP_ABC, M_ABC, 1'b0);
    checks++;
    if (ready_o !== 1'b0) begin failures++; $display("FAIL b2b_accept ready got=%b exp=0", ready_o); end
    checks++;
    if (done_o !== 1'b0) begin failures++; $display("FAIL b2b_done_pulse got=%b exp=0", done_o); end
    wait_done(100, 1'b1, lat, nd);
    checks++;
    if (lat !== 65) begin failures++; $display("FAIL b2b_latency got=%0d exp=65", lat); end
    checks++;
    if (h_o !== exp_chain) begin failures++; $display("FAIL b2b_chain_digest got=%h exp=%h", h_o, exp_chain); end
    repeat (5) @(negedge clk_i);
    checks++;
    if (h_o !== exp_chain) begin failures++; $display("FAIL b2b_hold got=%h exp=%h", h_o, exp_chain); end
    checks++;
    if (done_o !== 1'b0) begin failures++; $display("FAIL b2b_done_after got=%b exp=0", done_o); end
  endtask

  task automatic test_busy_start();
    int lat, nd;
    lat = -1; nd = 0;
    do_start(rnd128(), M_ABC, 1'b1);
    for (int c = 0; c < 100; c++) begin
      if (c == 64) begin
        checks++;
        if (ready_o !== 1'b0) begin failures++; $display("FAIL busy_ready_c64 got=%b exp=0", ready_o); end
      end
      if (done_o === 1'b1) begin nd++; if (lat < 0) lat = c; end
      start_i = (c == 10 || c == 64);
      init_i = 1'b0; h_i = rnd128(); m_i = M_EMPTY;
      @(negedge clk_i);
    end
    start_i = 1'b0;
    checks++;
    if (nd !== 1) begin failures++; $display("FAIL busy_done_count got=%0d exp=1", nd); end
    checks++;
    if (lat !== 65) begin failures++; $display("FAIL busy_latency got=%0d exp=65", lat); end
    checks++;
    if (h_o !== EXP_ABC) begin failures++; $display("FAIL busy_digest got=%h exp=%h", h_o, EXP_ABC); end
  endtask

  task automatic test_reset_mid_run();
    int lat, nd;
    do_start(128'h0, M_EMPTY, 1'b1);
    repeat (30) @(negedge clk_i);
    rst_i = 1'b1;
    @(negedge clk_i);
    rst_i = 1'b0;
    checks++;
    if (ready_o !== 1'b1) begin failures++; $display("FAIL midrst_ready got=%b exp=1", ready_o); end
    checks++;
    if (done_o !== 1'b0) begin failures++; $display("FAIL midrst_done got=%b exp=0", done_o); end
    checks++;
    if (h_o !== 128'h0) begin failures++; $display("FAIL midrst_h_o got=%h exp=0", h_o); end
    wait_done(80, 1'b0, lat, nd);
    checks++;
    if (nd !== 0) begin failures++; $display("FAIL midrst_discard done_count got=%0d exp=0", nd); end
    do_start(128'h0, M_EMPTY, 1'b1);
    wait_done(100, 1'b0, lat, nd);
    checks++;
    if (lat !== 65) begin failures++; $display("FAIL midrst_fresh_latency got=%0d exp=65", lat); end
    checks++;
    if (h_o !== EXP_EMPTY) begin failures++; $display("FAIL midrst_fresh_digest got=%h exp=%h", h_o, EXP_EMPTY); end
  endtask

  initial begin
    rst_i = 1'b1; start_i = 1'b0; init_i = 1'b0; h_i = '0; m_i = '0;
    test_reset();
    test_empty();
    test_abc();
    test_back_to_back();
    test_busy_start();
    test_reset_mid_run();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
